// File: rtl/mux_nx1_scan.sv
// Registered N:1 channel multiplexer with valid/ready handshake and manual/scan channel selection.
// Optional feature: define MUX_NX1_SCAN_PARITY_EN to add the out_par port and its parity register.
module mux_nx1_scan #(
   parameter int N    = 8,
   parameter int W    = 1,
   parameter int SELW = $clog2(N)
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N*W-1:0]  din,
   input  logic [SELW-1:0] sel,
   input  logic            mode,
   input  logic            in_valid,
   output logic            in_ready,
   output logic [W-1:0]    out_data,
   output logic [SELW-1:0] out_chan,
   output logic            out_valid,
   input  logic            out_ready,
   output logic            out_last,
`ifdef MUX_NX1_SCAN_PARITY_EN
   output logic            out_par,
`endif
   output logic            sel_err
);

   localparam logic [SELW-1:0] LAST_CHAN = SELW'(N - 1);

   function automatic logic parity_f(input logic [W-1:0] v);
      return ^v;
   endfunction

   logic [SELW-1:0] chan_s;
   logic [W-1:0]    chan_data_s;
   logic            in_range_s;
   logic            in_ready_s;
   logic            accept_s;

   logic [W-1:0]    data_q, data_d;
   logic [SELW-1:0] chan_q, chan_d;
   logic [SELW-1:0] scan_q, scan_d;
   logic            valid_q, valid_d;
   logic            last_q, last_d;
   logic            err_q, err_d;
   logic            par_q, par_d;

   // Channel source and selected input word; an out-of-range index selects nothing and yields 0.
   always_comb begin
      chan_s      = mode ? scan_q : sel;
      chan_data_s = '0;
      in_range_s  = 1'b0;
      for (int k = 0; k < N; k++) begin
         if (chan_s == SELW'(k)) begin
            chan_data_s = din[k*W +: W];
            in_range_s  = 1'b1;
         end else begin
            chan_data_s = chan_data_s;
         end
      end
      in_ready_s = rst || !valid_q || out_ready;
      accept_s   = in_valid && in_ready_s;
   end

   // Next-state: capture on accept, drop valid on a drain-only cycle, otherwise hold.
   always_comb begin
      data_d  = data_q;
      chan_d  = chan_q;
      valid_d = valid_q;
      last_d  = last_q;
      err_d   = err_q;
      par_d   = par_q;
      if (accept_s) begin
         valid_d = 1'b1;
         data_d  = chan_data_s;
         chan_d  = chan_s;
         last_d  = mode && (chan_s == LAST_CHAN);
         par_d   = parity_f(chan_data_s);
         err_d   = err_q || (!mode && !in_range_s);
      end else if (out_ready) begin
         valid_d = 1'b0;
      end else begin
         valid_d = valid_q;
      end
      // Leaving scan mode rewinds the counter so each scan pass starts at channel 0.
      if (!mode) begin
         scan_d = '0;
      end else if (accept_s) begin
         scan_d = (scan_q == LAST_CHAN) ? '0 : scan_q + SELW'(1);
      end else begin
         scan_d = scan_q;
      end
   end

   // State registers with synchronous reset; a pending sample is discarded on reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         data_q  <= '0;
         chan_q  <= '0;
         scan_q  <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         err_q   <= 1'b0;
         par_q   <= 1'b0;
      end else begin
         data_q  <= data_d;
         chan_q  <= chan_d;
         scan_q  <= scan_d;
         valid_q <= valid_d;
         last_q  <= last_d;
         err_q   <= err_d;
         par_q   <= par_d;
      end
   end

   assign in_ready  = in_ready_s;
   assign out_data  = data_q;
   assign out_chan  = chan_q;
   assign out_valid = valid_q;
   assign out_last  = last_q;
   assign sel_err   = err_q;
`ifdef MUX_NX1_SCAN_PARITY_EN
   assign out_par   = par_q;
`else
   logic unused_par_s;
   assign unused_par_s = par_q;
`endif

endmodule

// File: tb/tb_mux_nx1_scan.sv
// Bench for mux_nx1_scan: two instances (N=8 and N=6, W=4) driven by shared controls and
// compared every cycle against a behavioural model of the capture/drain/scan rules.
module tb_mux_nx1_scan;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  sel;
   logic        mode;
   logic        in_valid;
   logic        out_ready;
   logic [63:0] din_m [2];

   logic        rdy [2];
   logic [3:0]  dat [2];
   logic [2:0]  chn [2];
   logic        vld [2];
   logic        lst [2];
   logic        err [2];
   logic        par [2];

   int total = 0;
   int bad   = 0;

   // model state
   bit       m_valid [2];
   bit [3:0] m_data  [2];
   int       m_chan  [2];
   bit       m_last  [2];
   bit       m_err   [2];
   bit       m_par   [2];
   int       m_cnt   [2];
   int       nv      [2] = '{8, 6};

   always #5 clk = ~clk;

   mux_nx1_scan #(.N(8), .W(4)) u_a (
      .clk(clk), .rst(rst), .din(din_m[0][31:0]), .sel(sel), .mode(mode),
      .in_valid(in_valid), .in_ready(rdy[0]), .out_data(dat[0]), .out_chan(chn[0]),
      .out_valid(vld[0]), .out_ready(out_ready), .out_last(lst[0]),
`ifdef MUX_NX1_SCAN_PARITY_EN
      .out_par(par[0]),
`endif
      .sel_err(err[0])
   );

   mux_nx1_scan #(.N(6), .W(4)) u_b (
      .clk(clk), .rst(rst), .din(din_m[1][23:0]), .sel(sel), .mode(mode),
      .in_valid(in_valid), .in_ready(rdy[1]), .out_data(dat[1]), .out_chan(chn[1]),
      .out_valid(vld[1]), .out_ready(out_ready), .out_last(lst[1]),
`ifdef MUX_NX1_SCAN_PARITY_EN
      .out_par(par[1]),
`endif
      .sel_err(err[1])
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      if (obs !== exp) begin
         bad++;
         $display("FAIL %s at %0t: got %0h, want %0h", tag, $time, obs, exp);
      end
   endtask

   task automatic model_step(input int i);
      bit acc;
      int ch;
      if (rst) begin
         m_valid[i] = 0; m_data[i] = 0; m_chan[i] = 0; m_last[i] = 0;
         m_err[i] = 0; m_par[i] = 0; m_cnt[i] = 0;
      end else begin
         acc = in_valid && (!m_valid[i] || out_ready);
         ch  = mode ? m_cnt[i] : int'(sel);
         if (acc) begin
            m_valid[i] = 1;
            m_chan[i]  = ch;
            m_last[i]  = mode && (ch == nv[i] - 1);
            if (ch >= nv[i]) begin
               m_data[i] = 0;
               m_par[i]  = 0;
               m_err[i]  = 1;
            end else begin
               m_data[i] = din_m[i][ch*4 +: 4];
               m_par[i]  = ^m_data[i];
            end
         end else if (out_ready) begin
            m_valid[i] = 0;
         end
         if (!mode)    m_cnt[i] = 0;
         else if (acc) m_cnt[i] = (m_cnt[i] + 1) % nv[i];
      end
   endtask

   task automatic check_outs(input int i);
      string nm;
      nm = (i == 0) ? "n8" : "n6";
      check_eq({nm, "_valid"}, 64'(vld[i]), 64'(m_valid[i]));
      check_eq({nm, "_data"},  64'(dat[i]), 64'(m_data[i]));
      check_eq({nm, "_chan"},  64'(chn[i]), 64'(m_chan[i]));
      check_eq({nm, "_last"},  64'(lst[i]), 64'(m_last[i]));
      check_eq({nm, "_err"},   64'(err[i]), 64'(m_err[i]));
`ifdef MUX_NX1_SCAN_PARITY_EN
      check_eq({nm, "_par"},   64'(par[i]), 64'(m_par[i]));
`endif
   endtask

   // one clock: apply inputs, check in_ready, advance model, check registered outputs
   task automatic drv(input logic r, input logic md, input logic [2:0] sl,
                      input logic iv, input logic ordy);
      rst = r; mode = md; sel = sl; in_valid = iv; out_ready = ordy;
      #1;
      for (int i = 0; i < 2; i++)
         check_eq((i == 0) ? "n8_in_ready" : "n6_in_ready", 64'(rdy[i]),
                  64'(r || !m_valid[i] || ordy));
      model_step(0);
      model_step(1);
      @(posedge clk);
      #1;
      check_outs(0);
      check_outs(1);
   endtask

   initial begin
      logic [7:0] pat;
      pat = 8'b1010_1101;
      rst = 1'b1; sel = 3'd0; mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      din_m[0] = 64'd0; din_m[1] = 64'd0;
      #1;
      drv(1'b1, 1'b0, 3'd0, 1'b0, 1'b0);
      drv(1'b1, 1'b0, 3'd0, 1'b1, 1'b0);

      // manual sweep, channel k carries bit k of the pattern
      for (int k = 0; k < 8; k++) din_m[0][k*4 +: 4] = {3'b000, pat[k]};
      for (int k = 0; k < 6; k++) din_m[1][k*4 +: 4] = 4'(k + 9);
      for (int s = 0; s < 8; s++) drv(1'b0, 1'b0, 3'(s), 1'b1, 1'b1);
      drv(1'b1, 1'b0, 3'd0, 1'b0, 1'b1);

      // scan with din[k]=k+3 for 10 accepts
      for (int k = 0; k < 8; k++) din_m[0][k*4 +: 4] = 4'(k + 3);
      for (int c = 0; c < 10; c++) drv(1'b0, 1'b1, 3'd5, 1'b1, 1'b1);

      // backpressure after first scan capture, then release
      drv(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
      drv(1'b0, 1'b1, 3'd0, 1'b1, 1'b1);
      for (int c = 0; c < 3; c++) drv(1'b0, 1'b1, 3'd0, 1'b1, 1'b0);
      drv(1'b0, 1'b1, 3'd0, 1'b1, 1'b1);
      drv(1'b0, 1'b1, 3'd0, 1'b1, 1'b1);

      // out-of-range manual select on the N=6 instance, then a legal one
      drv(1'b0, 1'b0, 3'd7, 1'b1, 1'b1);
      drv(1'b0, 1'b0, 3'd2, 1'b1, 1'b1);
      drv(1'b0, 1'b0, 3'd2, 1'b0, 1'b1);
      drv(1'b0, 1'b0, 3'd6, 1'b1, 1'b0);

      // reset mid-scan at channel 4, then first scan accept must be channel 0
      drv(1'b0, 1'b0, 3'd0, 1'b0, 1'b1);
      for (int c = 0; c < 5; c++) drv(1'b0, 1'b1, 3'd0, 1'b1, 1'b1);
      drv(1'b1, 1'b1, 3'd0, 1'b1, 1'b1);
      drv(1'b0, 1'b1, 3'd0, 1'b1, 1'b1);

      // parity of a selected word
      din_m[0][12 +: 4] = 4'b1011; din_m[1][12 +: 4] = 4'b1011;
      drv(1'b0, 1'b0, 3'd3, 1'b1, 1'b1);
      din_m[0][12 +: 4] = 4'b1001; din_m[1][12 +: 4] = 4'b1001;
      drv(1'b0, 1'b0, 3'd3, 1'b1, 1'b1);

      // randomized mix, mode held in short runs
      for (int c = 0; c < 600; c++) begin
         logic md_r;
         din_m[0] = {$urandom, $urandom};
         din_m[1] = {$urandom, $urandom};
         md_r = ($urandom_range(0, 7) == 0) ? ~mode : mode;
         drv(($urandom_range(0, 59) == 0), md_r, 3'($urandom_range(0, 7)),
             ($urandom_range(0, 3) != 0), ($urandom_range(0, 2) != 0));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
